// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package instr_queue_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Circular FIFO of {pc, instr} pairs between fetch and decode.
// Flush empties the queue so wrong-path words never reach decode.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [XLEN-1:0]        enq_pc,
  input  logic [XLEN-1:0]        enq_instr,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [XLEN-1:0]        deq_pc,
  output logic [XLEN-1:0]        deq_instr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          enq_fire;
  logic          deq_fire;

  // Full/empty come from cnt; a dequeue never frees space same-cycle.
  assign enq_ready = reset_n && !flush && (cnt != FULL);
  assign deq_valid = (cnt != '0) && !flush;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[wr_ptr] <= '{pc: enq_pc, instr: enq_instr};
    end
  end

  always_comb begin
    head = mem[rd_ptr];
    if (!deq_valid) begin
      head = '{pc: '0, instr: NOP_INSTR};
    end
  end

  assign deq_pc    = head.pc;
  assign deq_instr = head.instr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        enq_fire && !deq_fire: cnt <= cnt + 1'b1;
        deq_fire && !enq_fire: cnt <= cnt - 1'b1;
        default:               cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with a queue-based reference model.
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_instr;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;
  int flushed_seen = 0;

  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];

  instr_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_instr(enq_instr),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_instr(deq_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of words, cleared by reset or flush.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq_pc.delete();
      mq_in.delete();
    end else if (flush) begin
      mq_pc.delete();
      mq_in.delete();
    end else begin
      automatic bit can_enq = enq_valid && (mq_pc.size() < DEPTH);
      automatic bit can_deq = deq_ready && (mq_pc.size() > 0);
      if (can_deq) begin
        if (mq_pc[0] inside {32'h100, 32'h104, 32'h108}) flushed_seen++;
        void'(mq_pc.pop_front());
        void'(mq_in.pop_front());
      end
      if (can_enq) begin
        mq_pc.push_back(enq_pc);
        mq_in.push_back(enq_instr);
      end
    end
  end

  always @(negedge clk) begin
    automatic logic        e_rdy = reset_n && !flush && (mq_pc.size() < DEPTH);
    automatic logic        e_val = !flush && (mq_pc.size() > 0);
    automatic logic [31:0] e_pc  = e_val ? mq_pc[0] : 32'h0;
    automatic logic [31:0] e_in  = e_val ? mq_in[0] : NOP;
    chk("enq_ready", {31'b0, enq_ready}, {31'b0, e_rdy});
    chk("deq_valid", {31'b0, deq_valid}, {31'b0, e_val});
    chk("deq_pc", deq_pc, e_pc);
    chk("deq_instr", deq_instr, e_in);
    chk("count", {29'b0, count}, mq_pc.size());
    chk("count_le_depth", {31'b0, (count <= 3'(DEPTH))}, 32'd1);
    if (deq_valid) chk("pc_aligned", {30'b0, deq_pc[1:0]}, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] t2_in [3];

  initial begin
    t2_in[0] = 32'h00500093;
    t2_in[1] = 32'hFFE08113;
    t2_in[2] = 32'h00A10193;
    reset_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = '0; enq_instr = '0;
    #3;
    chk("rst_enq_ready", {31'b0, enq_ready}, 32'd0);
    chk("rst_deq_valid", {31'b0, deq_valid}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    step(); step(); step();
    chk("idle_valid", {31'b0, deq_valid}, 32'd0);
    chk("idle_instr", deq_instr, 32'h00000013);
    chk("idle_pc", deq_pc, 32'd0);
    chk("idle_ready", {31'b0, enq_ready}, 32'd1);
    chk("idle_count", {29'b0, count}, 32'd0);

    // In-order push of three words, then pop.
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1'b1; enq_pc = 32'(4 * i); enq_instr = t2_in[i];
      step();
      chk("t2_count_up", {29'b0, count}, 32'(i + 1));
      if (i == 0) begin
        chk("t2_first_valid", {31'b0, deq_valid}, 32'd1);
        chk("t2_first_pc", deq_pc, 32'd0);
      end
    end
    enq_valid = 1'b0; deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_pop_pc", deq_pc, 32'(4 * i));
      chk("t2_pop_instr", deq_instr, t2_in[i]);
      step();
      chk("t2_count_dn", {29'b0, count}, 32'(2 - i));
    end
    deq_ready = 1'b0;

    // Fill, stall the fifth word, free one slot.
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1; enq_pc = 32'(4 * i); enq_instr = 32'h1000_0000 + 32'(4 * i);
      step();
    end
    enq_pc = 32'd16; enq_instr = 32'h1000_0010;
    settle();
    chk("t3_full_ready", {31'b0, enq_ready}, 32'd0);
    step();
    chk("t3_full_count", {29'b0, count}, 32'd4);
    deq_ready = 1'b1;
    settle();
    chk("t3_nobypass", {31'b0, enq_ready}, 32'd0);
    chk("t3_pop0", deq_pc, 32'd0);
    step();
    deq_ready = 1'b0;
    settle();
    chk("t3_ready_back", {31'b0, enq_ready}, 32'd1);
    step();
    chk("t3_refill", {29'b0, count}, 32'd4);
    enq_valid = 1'b0; deq_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("t3_drain_pc", deq_pc, 32'(4 * i));
      step();
    end
    deq_ready = 1'b0;
    chk("t3_empty", {29'b0, count}, 32'd0);

    // Streaming through the pointer wrap.
    enq_valid = 1'b1; deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      enq_pc = 32'(4 * i); enq_instr = 32'h2000_0000 + 32'(i);
      settle();
      if (i > 0) chk("t4_stream_pc", deq_pc, 32'(4 * (i - 1)));
      step();
      chk("t4_count", {29'b0, count}, 32'd1);
    end
    enq_valid = 1'b0;
    settle();
    chk("t4_last_pc", deq_pc, 32'd36);
    step();
    deq_ready = 1'b0;

    // Flush with an enqueue in the same cycle.
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1'b1; enq_pc = 32'h100 + 32'(4 * i); enq_instr = 32'h3000_0000;
      step();
    end
    flush = 1'b1; enq_pc = 32'h40; enq_instr = 32'hDEAD_0000;
    settle();
    chk("t5_flush_valid", {31'b0, deq_valid}, 32'd0);
    chk("t5_flush_ready", {31'b0, enq_ready}, 32'd0);
    step();
    flush = 1'b0; enq_valid = 1'b0;
    chk("t5_post_count", {29'b0, count}, 32'd0);
    chk("t5_post_valid", {31'b0, deq_valid}, 32'd0);
    enq_valid = 1'b1; enq_pc = 32'h40; enq_instr = 32'h00500093;
    step();
    enq_valid = 1'b0;
    chk("t5_target_pc", deq_pc, 32'h40);
    chk("t5_target_instr", deq_instr, 32'h00500093);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;

    // Asynchronous reset with two entries held.
    for (int i = 0; i < 2; i++) begin
      enq_valid = 1'b1; enq_pc = 32'h200 + 32'(4 * i); enq_instr = 32'h4000_0000;
      step();
    end
    enq_valid = 1'b0;
    reset_n = 1'b0;
    settle();
    chk("t6_async_valid", {31'b0, deq_valid}, 32'd0);
    chk("t6_async_count", {29'b0, count}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    chk("t6_rel_valid", {31'b0, deq_valid}, 32'd0);
    chk("t6_rel_ready", {31'b0, enq_ready}, 32'd1);
    enq_valid = 1'b1; enq_pc = 32'h300; enq_instr = 32'h5000_0000;
    step();
    enq_valid = 1'b0; deq_ready = 1'b1;
    chk("t6_new_pc", deq_pc, 32'h300);
    step();
    deq_ready = 1'b0;
    step();
    chk("flushed_never_seen", flushed_seen, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
